fusion_accumulator: RTL

FUSION_ACCUMULATOR -- requirements
Module: fusion_accumulator

---
 rtl/fusion_pkg.sv | 51 +++++
 rtl/fusion_lane_sat_add.sv | 40 ++++
 rtl/fusion_accumulator.sv | 138 +++++++++++++
 3 files changed

// File: rtl/fusion_pkg.sv
`default_nettype none
// ============================================================================
// fusion_pkg : shared fusion-unit definitions (cfg encodings, lane modes, states)
// Revision   : 1.0
// ============================================================================
package fusion_pkg;

  localparam int FUSION_PROD_W  = 64;
  localparam int FUSION_FIELD_W = 16;
  localparam int FUSION_WIDE_W  = 32;

  localparam logic [1:0] CFG_2B      = 2'b00;
  localparam logic [1:0] CFG_4B      = 2'b01;
  localparam logic [1:0] CFG_8B      = 2'b10;
  localparam logic [1:0] CFG_ILLEGAL = 2'b11;

  typedef enum logic [1:0] {
    LM_1 = 2'd0,
    LM_2 = 2'd1,
    LM_4 = 2'd2
  } lane_mode_e;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ACCUM = 2'd1,
    HOLD  = 2'd2
  } acc_state_e;

  // Illegal encodings fall through to 4-lane mode.
  function automatic lane_mode_e decode_lane_mode(input logic [1:0] a, input logic [1:0] b);
    if (a == CFG_8B && b == CFG_8B) return LM_1;
    if ((a == CFG_8B && b == CFG_4B) || (a == CFG_4B && b == CFG_8B)) return LM_2;
    return LM_4;
  endfunction

  function automatic logic [2:0] lane_count(input lane_mode_e m);
    case (m)
      LM_1:    return 3'd1;
      LM_2:    return 3'd2;
      default: return 3'd4;
    endcase
  endfunction

  function automatic logic [FUSION_WIDE_W-1:0] extend16(input logic [FUSION_FIELD_W-1:0] v,
                                                        input logic s);
    return s ? {{(FUSION_WIDE_W-FUSION_FIELD_W){v[FUSION_FIELD_W-1]}}, v}
             : {{(FUSION_WIDE_W-FUSION_FIELD_W){1'b0}}, v};
  endfunction

endpackage
`default_nettype wire

// File: rtl/fusion_lane_sat_add.sv
`default_nettype none
// ============================================================================
// fusion_lane_sat_add : extend a 32-bit lane field and add it to an accumulator, saturating
// Revision            : 1.0
// ============================================================================
module fusion_lane_sat_add
  import fusion_pkg::*;
#(
  parameter int ACC_W = 32
) (
  input  logic [ACC_W-1:0]         acc_i,
  input  logic [FUSION_WIDE_W-1:0] field_i,
  input  logic                     sgn_i,
  output logic [ACC_W-1:0]         sum_o
);

  localparam logic [ACC_W-1:0] SMAX = {1'b0, {(ACC_W-1){1'b1}}};
  localparam logic [ACC_W-1:0] SMIN = {1'b1, {(ACC_W-1){1'b0}}};

  logic signed [ACC_W-1:0] ext_s;
  logic [ACC_W-1:0]        ext;
  logic [ACC_W:0]          sum_wide;

  assign ext_s = ACC_W'($signed(field_i));
  assign ext   = sgn_i ? ext_s : ACC_W'(field_i);

  // One guard bit: signed overflow shows as guard != msb, unsigned as a carry.
  always_comb begin
    if (sgn_i) sum_wide = {acc_i[ACC_W-1], acc_i} + {ext[ACC_W-1], ext};
    else       sum_wide = {1'b0, acc_i} + {1'b0, ext};
    sum_o = sum_wide[ACC_W-1:0];
    if (sgn_i) begin
      if (sum_wide[ACC_W] != sum_wide[ACC_W-1]) sum_o = sum_wide[ACC_W] ? SMIN : SMAX;
    end else if (sum_wide[ACC_W]) begin
      sum_o = '1;
    end
  end

endmodule
`default_nettype wire

// File: rtl/fusion_accumulator.sv
`default_nettype none
// ============================================================================
// fusion_accumulator : groups packed fusion-unit products into 1/2/4 saturating lane sums
// Revision           : 1.0
// ============================================================================
module fusion_accumulator
  import fusion_pkg::*;
#(
  parameter int ACC_W = 32
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic [FUSION_PROD_W-1:0] in_data,
  input  logic [1:0]               cfga,
  input  logic [1:0]               cfgb,
  input  logic                     sgn,
  input  logic                     in_last,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [4*ACC_W-1:0]       out_data,
  output logic [2:0]               out_lanes,
  output logic                     cfg_err
);

  acc_state_e       state_q;
  logic             in_ready_q;
  logic             out_valid_q;
  logic             cfg_err_q;
  logic [1:0]       cfga_q;
  logic [1:0]       cfgb_q;
  logic             sgn_q;
  logic [ACC_W-1:0] acc_q [4];
  logic [ACC_W-1:0] acc_d [4];

  logic [FUSION_WIDE_W-1:0] field [4];
  logic [3:0]               lane_en;
  logic                     xfer;
  logic                     first_beat;
  logic                     eff_sgn;
  logic                     beat_err;
  lane_mode_e               eff_mode;

  assign xfer       = in_valid & in_ready_q;
  assign first_beat = (state_q == IDLE);

  // The first beat of a group defines the mode; later beats reuse the latched one.
  assign eff_mode = first_beat ? decode_lane_mode(cfga, cfgb) : decode_lane_mode(cfga_q, cfgb_q);
  assign eff_sgn  = first_beat ? sgn : sgn_q;
  assign beat_err = first_beat ? ((cfga == CFG_ILLEGAL) || (cfgb == CFG_ILLEGAL))
                               : ((cfga != cfga_q) || (cfgb != cfgb_q) || (sgn != sgn_q));

  always_comb begin
    lane_en = 4'b0000;
    for (int k = 0; k < 4; k++) field[k] = '0;
    case (eff_mode)
      LM_1: begin
        field[0]   = extend16(in_data[15:0], eff_sgn);
        lane_en[0] = 1'b1;
      end
      LM_2: begin
        field[0] = in_data[31:0];
        field[1] = in_data[63:32];
        lane_en  = 4'b0011;
      end
      default: begin
        for (int k = 0; k < 4; k++) field[k] = extend16(in_data[16*k +: 16], eff_sgn);
        lane_en = 4'b1111;
      end
    endcase
  end

  for (genvar k = 0; k < 4; k++) begin : g_lane
    fusion_lane_sat_add #(.ACC_W(ACC_W)) u_lane (
      .acc_i  (acc_q[k]),
      .field_i(field[k]),
      .sgn_i  (eff_sgn),
      .sum_o  (acc_d[k])
    );
    assign out_data[k*ACC_W +: ACC_W] = acc_q[k];
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= IDLE;
      in_ready_q  <= 1'b0;
      out_valid_q <= 1'b0;
      cfg_err_q   <= 1'b0;
      cfga_q      <= '0;
      cfgb_q      <= '0;
      sgn_q       <= 1'b0;
      for (int k = 0; k < 4; k++) acc_q[k] <= '0;
    end else begin
      case (state_q)
        IDLE, ACCUM: begin
          in_ready_q <= 1'b1;
          if (xfer) begin
            if (first_beat) begin
              cfga_q <= cfga;
              cfgb_q <= cfgb;
              sgn_q  <= sgn;
            end
            if (beat_err) cfg_err_q <= 1'b1;
            for (int k = 0; k < 4; k++) if (lane_en[k]) acc_q[k] <= acc_d[k];
            if (in_last) begin
              state_q     <= HOLD;
              in_ready_q  <= 1'b0;
              out_valid_q <= 1'b1;
            end else begin
              state_q <= ACCUM;
            end
          end
        end
        HOLD: begin
          if (out_ready) begin
            state_q     <= IDLE;
            in_ready_q  <= 1'b1;
            out_valid_q <= 1'b0;
            for (int k = 0; k < 4; k++) acc_q[k] <= '0;
          end
        end
        default: begin
          state_q     <= IDLE;
          in_ready_q  <= 1'b0;
          out_valid_q <= 1'b0;
        end
      endcase
    end
  end

  assign in_ready  = in_ready_q;
  assign out_valid = out_valid_q;
  assign cfg_err   = cfg_err_q;
  assign out_lanes = lane_count(decode_lane_mode(cfga_q, cfgb_q));

endmodule
`default_nettype wire
